garage_input_conditioner: RTL

- Front-end stage directly upstream of the garage door controller; turns the raw board button and safety inputs into clean signals for it.
- Synchronises both asynchronous pins to sys_clk and debounces them.
- Emits a single-cycle press pulse per genuine button press, plus a fail-safe debounced safety level.
- The controller consumes press_pulse as its button input and safety_db as its safety input.

---
 rtl/garage_pkg.sv | 33 +++
 rtl/garage_input_conditioner_sync2.sv | 26 ++
 rtl/garage_input_conditioner.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/garage_pkg.sv
// Purpose: shared constants and types for the garage door front end and controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: system clock rate, default debounce/safety hold times derived from it,
// button FSM state encoding and a constant max helper for counter sizing.
package garage_pkg;

    localparam int CLK_HZ = 50_000_000;

    // 20 ms button debounce and 5 ms safety release hold at CLK_HZ.
    localparam int DB_CYCLES_DEF   = CLK_HZ / 50;
    localparam int SAFE_CYCLES_DEF = CLK_HZ / 200;

    // Raw encodings kept as plain constants so older code that compares
    // against literal 2-bit values stays compatible with the enum below.
    localparam logic [1:0] ST_LOW       = 2'd0;
    localparam logic [1:0] ST_WAIT_HIGH = 2'd1;
    localparam logic [1:0] ST_HIGH      = 2'd2;
    localparam logic [1:0] ST_WAIT_LOW  = 2'd3;

    typedef enum logic [1:0] {
        LOW       = ST_LOW,
        WAIT_HIGH = ST_WAIT_HIGH,
        HIGH      = ST_HIGH,
        WAIT_LOW  = ST_WAIT_LOW
    } btn_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/garage_input_conditioner_sync2.sv
// Purpose: two-flop synchroniser bringing one asynchronous pin into sys_clk.
// Latency: 2 cycles from pin to q.
// Backpressure: none; samples every cycle.
//
// Ports: sys_clk (clock), rst (async active-high, clears both stages to 0),
//        d (asynchronous input), q (synchronised output).
module sync2 (
    input  logic sys_clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/garage_input_conditioner.sv
// Purpose: synchronise and debounce the garage button and safety pins for the door controller.
// Latency: button edge to press_pulse 2 + DB_CYCLES + 1 cycles; safety assert 3 cycles, release after SAFE_CYCLES low.
// Backpressure: none; press pulses are dropped (never queued) while safety_db is high.
//
// Ports: sys_clk (50 MHz clock), rst (async active-high),
//        button_raw / safety_raw (asynchronous pins, 1 = pressed / obstructed),
//        button_db (debounced button level), press_pulse (one cycle per accepted press),
//        safety_db (fail-safe safety level, 1 = obstructed),
//        glitch_cnt [7:0] (only when GLITCH_COUNT_EN is defined: saturating count of
//        aborted button transitions).
// Parameters DB_CYCLES and SAFE_CYCLES must both be at least 2.
module garage_input_conditioner
    import garage_pkg::*;
#(
    parameter int DB_CYCLES   = DB_CYCLES_DEF,
    parameter int SAFE_CYCLES = SAFE_CYCLES_DEF
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       button_raw,
    input  logic       safety_raw,
    output logic       button_db,
    output logic       press_pulse,
    output logic       safety_db
`ifdef GLITCH_COUNT_EN
    ,
    output logic [7:0] glitch_cnt
`endif
);

    localparam int CNT_W = $clog2(max_int(DB_CYCLES, SAFE_CYCLES) + 1);

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] SAFE_LAST = CNT_W'(SAFE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic btn_s;
    logic saf_s;

    sync2 u_sync_btn (
        .sys_clk (sys_clk),
        .rst     (rst),
        .d       (button_raw),
        .q       (btn_s)
    );

    sync2 u_sync_saf (
        .sys_clk (sys_clk),
        .rst     (rst),
        .d       (safety_raw),
        .q       (saf_s)
    );

    // ------------------------------------------------------------------
    // Button channel
    // ------------------------------------------------------------------
    btn_state_e       btn_state;
    btn_state_e       btn_state_nxt;
    logic [CNT_W-1:0] btn_cnt;
    logic [CNT_W-1:0] btn_cnt_nxt;
    logic             go_high;
    logic             btn_abort;

    always_comb begin
        btn_state_nxt = btn_state;
        btn_cnt_nxt   = btn_cnt;
        go_high       = 1'b0;
        btn_abort     = 1'b0;
        case (btn_state)
            LOW: begin
                if (btn_s) begin
                    btn_state_nxt = WAIT_HIGH;
                    btn_cnt_nxt   = '0;
                end
            end
            WAIT_HIGH: begin
                if (!btn_s) begin
                    btn_state_nxt = LOW;
                    btn_cnt_nxt   = '0;
                    btn_abort     = 1'b1;
                end else if (btn_cnt == DB_LAST) begin
                    btn_state_nxt = HIGH;
                    btn_cnt_nxt   = '0;
                    go_high       = 1'b1;
                end else begin
                    btn_cnt_nxt = btn_cnt + CNT_ONE;
                end
            end
            HIGH: begin
                if (!btn_s) begin
                    btn_state_nxt = WAIT_LOW;
                    btn_cnt_nxt   = '0;
                end
            end
            WAIT_LOW: begin
                if (btn_s) begin
                    btn_state_nxt = HIGH;
                    btn_cnt_nxt   = '0;
                    btn_abort     = 1'b1;
                end else if (btn_cnt == DB_LAST) begin
                    btn_state_nxt = LOW;
                    btn_cnt_nxt   = '0;
                end else begin
                    btn_cnt_nxt = btn_cnt + CNT_ONE;
                end
            end
            default: begin
                btn_state_nxt = LOW;
                btn_cnt_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Safety channel: asserts immediately on any high sample, releases only
    // after SAFE_CYCLES consecutive low samples.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] saf_cnt;
    logic [CNT_W-1:0] saf_cnt_nxt;
    logic             safety_db_nxt;

    always_comb begin
        safety_db_nxt = safety_db;
        saf_cnt_nxt   = saf_cnt;
        if (saf_s) begin
            safety_db_nxt = 1'b1;
            saf_cnt_nxt   = '0;
        end else if (safety_db) begin
            if (saf_cnt == SAFE_LAST) begin
                safety_db_nxt = 1'b0;
                saf_cnt_nxt   = '0;
            end else begin
                saf_cnt_nxt = saf_cnt + CNT_ONE;
            end
        end
    end

    // Reset parks the button FSM in HIGH so a button held through reset has to
    // be released before a press can be accepted. button_db is registered from
    // the next state so it still reads 0 while reset is asserted.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            btn_state   <= HIGH;
            btn_cnt     <= '0;
            button_db   <= 1'b0;
            press_pulse <= 1'b0;
            saf_cnt     <= '0;
            safety_db   <= 1'b1;
        end else begin
            btn_state   <= btn_state_nxt;
            btn_cnt     <= btn_cnt_nxt;
            button_db   <= (btn_state_nxt == HIGH) || (btn_state_nxt == WAIT_LOW);
            // Gate with the safety level that will be visible alongside the
            // pulse, so the controller never sees a press while obstructed.
            press_pulse <= go_high && !safety_db_nxt;
            saf_cnt     <= saf_cnt_nxt;
            safety_db   <= safety_db_nxt;
        end
    end

`ifdef GLITCH_COUNT_EN
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            glitch_cnt <= 8'd0;
        end else if (btn_abort && (glitch_cnt != 8'hFF)) begin
            glitch_cnt <= glitch_cnt + 8'd1;
        end
    end
`else
    // Abort strobe only feeds the optional counter.
    logic unused_abort;
    assign unused_abort = btn_abort;
`endif

endmodule
